lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit directly downstream of the ALU stage.
- Consumes LSU_OP[5:0], the effective address O and the store data D produced by the ALU.
- Runs a single-outstanding request/acknowledge transaction on the data-memory bus.
- Returns extracted, extended load data to the register file on write port 2, and stalls the pipeline while a transaction is in flight.

Parameters:
TIMEOUT, 255, cycles MREQ may stay high without MACK before abort (used only with LSU_TIMEOUT_EN); counter is 8 bits wide.

Ports:
CLK  input  1  clock, rising edge
N_RST  input  1  asynchronous active-low reset
LSU_OP  input  6  [0]=LD, [1]=ST, [3:2]=size (00 byte, 01 half, 10 word, 11 reserved), [4]=sign-extend load, [5]=ignored
O  input  32  effective address from ALU
D  input  32  store data from ALU
WA  input  5  load destination register
STALL  output  1  pipeline hold request
MREQ  output  1  bus request
MWE  output  1  bus write enable
MADDR  output  30  word address (O[31:2])
MBE  output  4  byte enables, little-endian lanes
MWDATA  output  32  bus write data
MACK  input  1  bus acknowledge; MRDATA valid when high
MRDATA  input  32  bus read data
WE2  output  1  register write enable (one-cycle pulse)
WA2  output  5  register write address
WD2  output  32  register write data
MISALIGN  output  1  one-cycle fault pulse
BUSERR  output  1  one-cycle timeout pulse

Behaviour:
- All outputs are registered except STALL. Reset forces every output to 0 and the state to IDLE asynchronously. Reset mid-transaction drops MREQ at once and discards the transaction; no WE2 follows.
- Valid op: exactly one of LD/ST is set and size is not 11. Any other LSU_OP value is a no-op: no bus access, no fault.
- Alignment: a half access with O[0]=1, or a word access with O[1:0]!=0, is misaligned. A misaligned op pulses MISALIGN on the next cycle, makes no bus access and stays in IDLE.
- States:
  - IDLE -> REQ on an aligned valid op. The op is captured at this edge: MADDR, MBE, MWE, MWDATA, WA, size/sign and O[1:0].
  - REQ: MREQ=1 with all bus outputs stable. When MACK=1 at an edge:
    - MREQ, MWE and MBE clear on that edge.
    - Load: MRDATA is captured and the state goes to WB.
    - Store: the state goes to IDLE.
  - WB: WE2=1, WA2=captured WA, WD2=extracted data; the next state is IDLE. WE2 is low in every other state.
- STALL = (state==REQ) | (state==WB). The op presented in IDLE is consumed in that cycle. The op presented while STALL is high is held by upstream and accepted on the first IDLE cycle.
- MACK sampled in IDLE or WB is ignored. MACK in the first REQ cycle gives a one-cycle MREQ.
- MBE:
  - byte: 1<<O[1:0]
  - half: O[1]=0 -> 0011, O[1]=1 -> 1100
  - word: 1111
- MWDATA:
  - byte: D[7:0] replicated on all 4 lanes
  - half: D[15:0] replicated on both halves
  - word: D
- Load extraction: R = MRDATA >> (8*O[1:0]). Byte uses R[7:0], half uses R[15:0]. Bit [4] selects sign or zero extension to 32 bits; word loads pass through unchanged.
- Latency:
  - Store: 1 cycle accept + N bus wait cycles.
  - Load: same as store, plus 1 WB cycle; WE2 asserts the cycle after MACK.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without MACK.
  - When the counter reaches TIMEOUT: MREQ drops, BUSERR pulses for one cycle, the state returns to IDLE, and no WE2 follows.
  - MACK arriving in the same cycle as the timeout wins; that is a normal completion.
- LSU_TIMEOUT_EN undefined: REQ waits indefinitely, BUSERR is tied to 0 and no counter exists.

Test Plan:
- Word store: LSU_OP=6'b001010, O=32'h00001004, D=32'hDEADBEEF, MACK on the 3rd REQ cycle -> MADDR=30'h401, MBE=1111, MWE=1, MWDATA=DEADBEEF. STALL high 3 cycles; no WE2.
- Signed byte load: LSU_OP=6'b010001, O=32'h00000203, WA=5, MRDATA=32'h80FF1234, MACK in the 1st REQ cycle -> MBE=1000; next cycle WE2=1, WA2=5, WD2=32'hFFFFFF80.
- Unsigned half load at O=...02 with MRDATA=32'hABCD0000 -> MBE=1100, WD2=32'h0000ABCD. Byte store of D=32'h12345677 at O=...01 -> MWDATA=77777777, MBE=0010.
- Misaligned word load at O=32'h00000006 -> MISALIGN pulse next cycle; MREQ, STALL and WE2 stay 0. LSU_OP=6'b000011 -> no activity.
- Back-to-back: load then store, with the store presented while STALL is high -> store accepted only on the first IDLE cycle, its MREQ rises the cycle after. Assert N_RST low during the load's REQ -> MREQ, STALL and WE2 drop immediately; no WE2 after release.
- With LSU_TIMEOUT_EN, TIMEOUT=4, MACK never asserted -> MREQ high exactly 4 cycles, BUSERR one-cycle pulse, state back to IDLE, no WE2.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: single-outstanding MREQ/MACK data bus transaction with load extraction and write-back.
// Optional bus timeout abort is compiled in with `define LSU_TIMEOUT_EN.
module lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        N_RST,
    input  logic [5:0]  LSU_OP,
    input  logic [31:0] O,
    input  logic [31:0] D,
    input  logic [4:0]  WA,
    output logic        STALL,
    output logic        MREQ,
    output logic        MWE,
    output logic [29:0] MADDR,
    output logic [3:0]  MBE,
    output logic [31:0] MWDATA,
    input  logic        MACK,
    input  logic [31:0] MRDATA,
    output logic        WE2,
    output logic [4:0]  WA2,
    output logic [31:0] WD2,
    output logic        MISALIGN,
    output logic        BUSERR
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t      state_q;
    logic        mreq_q;
    logic        mwe_q;
    logic [29:0] maddr_q;
    logic [3:0]  mbe_q;
    logic [31:0] mwdata_q;
    logic        we2_q;
    logic [4:0]  wa2_q;
    logic [31:0] wd2_q;
    logic        misalign_q;
    logic [4:0]  wa_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        sign_q;

    logic        op_ld;
    logic        op_st;
    logic [1:0]  op_size;
    logic        op_valid;
    logic        op_misaligned;
    logic        op_unused;
    logic [3:0]  mbe_d;
    logic [31:0] mwdata_d;
    logic [31:0] shifted;
    logic [31:0] load_data_d;

    assign op_ld     = LSU_OP[0];
    assign op_st     = LSU_OP[1];
    assign op_size   = LSU_OP[3:2];
    assign op_unused = LSU_OP[5];
    assign op_valid  = (op_ld ^ op_st) && (op_size != 2'b11);
    assign op_misaligned = ((op_size == 2'b01) && O[0]) ||
                           ((op_size == 2'b10) && (O[1:0] != 2'b00));

    // Lane enables and replicated write data for the op being presented.
    always_comb begin
        mbe_d    = 4'b0000;
        mwdata_d = D;
        case (op_size)
            2'b00: begin
                mbe_d    = 4'b0001 << O[1:0];
                mwdata_d = {4{D[7:0]}};
            end
            2'b01: begin
                mbe_d    = O[1] ? 4'b1100 : 4'b0011;
                mwdata_d = {2{D[15:0]}};
            end
            2'b10:   mbe_d = 4'b1111;
            default: mbe_d = 4'b0000;
        endcase
    end

    // Word accesses are aligned, so the shift is a pass-through for them.
    assign shifted = MRDATA >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   load_data_d = {{24{sign_q & shifted[7]}},  shifted[7:0]};
            2'b01:   load_data_d = {{16{sign_q & shifted[15]}}, shifted[15:0]};
            default: load_data_d = shifted;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q;
    logic       buserr_q;
    assign BUSERR = buserr_q;
`else
    localparam int unsigned TIMEOUT_UNUSED = TIMEOUT;
    assign BUSERR = 1'b0;
`endif

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state_q    <= IDLE;
            mreq_q     <= 1'b0;
            mwe_q      <= 1'b0;
            maddr_q    <= '0;
            mbe_q      <= '0;
            mwdata_q   <= '0;
            we2_q      <= 1'b0;
            wa2_q      <= '0;
            wd2_q      <= '0;
            misalign_q <= 1'b0;
            wa_q       <= '0;
            size_q     <= '0;
            off_q      <= '0;
            sign_q     <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= '0;
            buserr_q   <= 1'b0;
`endif
        end else begin
            misalign_q <= 1'b0;
            we2_q      <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            buserr_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (op_valid) begin
                        if (op_misaligned) begin
                            misalign_q <= 1'b1;
                        end else begin
                            state_q  <= REQ;
                            mreq_q   <= 1'b1;
                            mwe_q    <= op_st;
                            maddr_q  <= O[31:2];
                            mbe_q    <= mbe_d;
                            mwdata_q <= mwdata_d;
                            wa_q     <= WA;
                            size_q   <= op_size;
                            sign_q   <= LSU_OP[4];
                            off_q    <= O[1:0];
`ifdef LSU_TIMEOUT_EN
                            cnt_q    <= '0;
`endif
                        end
                    end
                end
                REQ: begin
                    // MACK in the abort cycle still completes normally.
                    if (MACK) begin
                        mreq_q <= 1'b0;
                        mwe_q  <= 1'b0;
                        mbe_q  <= 4'b0000;
                        if (!mwe_q) begin
                            we2_q   <= 1'b1;
                            wa2_q   <= wa_q;
                            wd2_q   <= load_data_d;
                            state_q <= WB;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (cnt_q == TMO_LAST) begin
                        mreq_q   <= 1'b0;
                        mwe_q    <= 1'b0;
                        mbe_q    <= 4'b0000;
                        buserr_q <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
`endif
                end
                WB:      state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign STALL    = (state_q == REQ) || (state_q == WB);
    assign MREQ     = mreq_q;
    assign MWE      = mwe_q;
    assign MADDR    = maddr_q;
    assign MBE      = mbe_q;
    assign MWDATA   = mwdata_q;
    assign WE2      = we2_q;
    assign WA2      = wa2_q;
    assign WD2      = wd2_q;
    assign MISALIGN = misalign_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized ops against a lane-level reference model.
// The timeout section is active when LSU_TIMEOUT_EN is defined for the build.
module tb_lsu;

    localparam int unsigned TMO = 4;

    logic        CLK = 1'b0;
    logic        N_RST;
    logic [5:0]  LSU_OP;
    logic [31:0] O;
    logic [31:0] D;
    logic [4:0]  WA;
    logic        STALL;
    logic        MREQ;
    logic        MWE;
    logic [29:0] MADDR;
    logic [3:0]  MBE;
    logic [31:0] MWDATA;
    logic        MACK;
    logic [31:0] MRDATA;
    logic        WE2;
    logic [4:0]  WA2;
    logic [31:0] WD2;
    logic        MISALIGN;
    logic        BUSERR;

    int total = 0;
    int bad   = 0;

    lsu #(.TIMEOUT(TMO)) dut (
        .CLK(CLK), .N_RST(N_RST), .LSU_OP(LSU_OP), .O(O), .D(D), .WA(WA),
        .STALL(STALL), .MREQ(MREQ), .MWE(MWE), .MADDR(MADDR), .MBE(MBE),
        .MWDATA(MWDATA), .MACK(MACK), .MRDATA(MRDATA), .WE2(WE2), .WA2(WA2),
        .WD2(WD2), .MISALIGN(MISALIGN), .BUSERR(BUSERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: lanes covered by an access of 2**sz bytes starting at byte off.
    function automatic logic [3:0] model_mbe(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] m;
        int n, o;
        m = 4'b0000;
        n = 1 << sz;
        o = int'(off);
        for (int l = 0; l < 4; l++)
            if (l >= o && l < o + n) m[l] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] m;
        int n;
        n = 1 << sz;
        for (int l = 0; l < 4; l++) m[8*l +: 8] = d[8*(l % n) +: 8];
        return m;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] sz,
                                               input logic [1:0] off, input logic sgn);
        longint r, v, span;
        int n;
        n = 1 << sz;
        if (n == 4) return rd;
        r    = {32'b0, rd} >> (8 * int'(off));
        span = longint'(1) << (8 * n);
        v    = r % span;
        if (sgn && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    // Presents one op in IDLE and follows it to completion; MACK on the ack-th REQ cycle.
    task automatic run_op(input logic [5:0] op, input logic [31:0] o, input logic [31:0] d,
                          input logic [4:0] wa, input int ack, input logic [31:0] rd);
        logic [1:0] sz, off;
        logic valid, aligned, is_ld;
        sz      = op[3:2];
        off     = o[1:0];
        is_ld   = op[0];
        valid   = (op[0] != op[1]) && (sz != 2'b11);
        aligned = valid && ((int'(off) % (1 << sz)) == 0);
        $display("op=%b addr=%h data=%h wa=%0d ack=%0d rdata=%h", op, o, d, wa, ack, rd);
        LSU_OP = op; O = o; D = d; WA = wa;
        if (!valid) MACK = 1'b1;
        step();
        LSU_OP = 6'b0; MACK = 1'b0;
        if (!valid) begin
            check("nop_mreq", MREQ, 0);
            check("nop_stall", STALL, 0);
            check("nop_misalign", MISALIGN, 0);
            check("nop_we2", WE2, 0);
            return;
        end
        if (!aligned) begin
            check("mis_pulse", MISALIGN, 1);
            check("mis_mreq", MREQ, 0);
            check("mis_stall", STALL, 0);
            check("mis_we2", WE2, 0);
            step();
            check("mis_clear", MISALIGN, 0);
            check("mis_stall2", STALL, 0);
            return;
        end
        for (int i = 1; i <= ack; i++) begin
            MACK   = (i == ack);
            MRDATA = (i == ack) ? rd : $urandom;
            check("req_mreq", MREQ, 1);
            check("req_stall", STALL, 1);
            check("req_maddr", MADDR, o[31:2]);
            check("req_mbe", MBE, model_mbe(sz, off));
            check("req_mwe", MWE, op[1]);
            if (op[1]) check("req_mwdata", MWDATA, model_wdata(sz, d));
            check("req_we2", WE2, 0);
            step();
        end
        MACK = 1'b0;
        check("done_mreq", MREQ, 0);
        check("done_mbe", MBE, 0);
        check("done_buserr", BUSERR, 0);
        if (is_ld) begin
            check("wb_we2", WE2, 1);
            check("wb_wa2", WA2, wa);
            check("wb_wd2", WD2, model_load(rd, sz, off, op[4]));
            check("wb_stall", STALL, 1);
            MACK = 1'b1;
            step();
            MACK = 1'b0;
            check("post_we2", WE2, 0);
            check("post_mreq", MREQ, 0);
        end else begin
            check("st_we2", WE2, 0);
        end
        check("post_stall", STALL, 0);
    endtask

    initial begin
        logic [5:0] op;
        int r, cnt;
        N_RST = 1'b0; LSU_OP = 6'b0; O = '0; D = '0; WA = '0; MACK = 1'b0; MRDATA = '0;
        #12;
        check("rst_stall", STALL, 0);
        check("rst_mreq", MREQ, 0);
        check("rst_mwe", MWE, 0);
        check("rst_maddr", MADDR, 0);
        check("rst_mbe", MBE, 0);
        check("rst_mwdata", MWDATA, 0);
        check("rst_we2", WE2, 0);
        check("rst_wa2", WA2, 0);
        check("rst_wd2", WD2, 0);
        check("rst_misalign", MISALIGN, 0);
        check("rst_buserr", BUSERR, 0);
        N_RST = 1'b1;
        step();

        run_op(6'b001010, 32'h00001004, 32'hDEADBEEF, 5'd0, 3, 32'h0);
        run_op(6'b010001, 32'h00000203, 32'h0, 5'd5, 1, 32'h80FF1234);
        run_op(6'b000101, 32'h00000002, 32'h0, 5'd9, 2, 32'hABCD0000);
        run_op(6'b000010, 32'h00000001, 32'h12345677, 5'd0, 1, 32'h0);
        run_op(6'b001001, 32'h00000006, 32'h0, 5'd3, 1, 32'h0);
        run_op(6'b000011, 32'h00000010, 32'h0, 5'd3, 1, 32'h0);
        run_op(6'b110101, 32'h00000102, 32'h0, 5'd31, 2, 32'h8001FFFF);

        // Load followed by a store held upstream while STALL is high.
        $display("op=back_to_back load addr=00000040 then store addr=00000080");
        LSU_OP = 6'b001001; O = 32'h00000040; WA = 5'd7;
        step();
        LSU_OP = 6'b001010; O = 32'h00000080; D = 32'hCAFEF00D;
        check("b2b_req1_maddr", MADDR, 30'h10);
        MACK = 1'b1; MRDATA = 32'h13572468;
        step();
        MACK = 1'b0;
        check("b2b_wb_we2", WE2, 1);
        check("b2b_wb_wd2", WD2, 32'h13572468);
        check("b2b_wb_mreq", MREQ, 0);
        step();
        check("b2b_idle_stall", STALL, 0);
        check("b2b_idle_mreq", MREQ, 0);
        step();
        LSU_OP = 6'b0;
        check("b2b_st_mreq", MREQ, 1);
        check("b2b_st_mwe", MWE, 1);
        check("b2b_st_maddr", MADDR, 30'h20);
        check("b2b_st_mwdata", MWDATA, 32'hCAFEF00D);
        MACK = 1'b1;
        step();
        MACK = 1'b0;
        check("b2b_st_done", MREQ, 0);
        check("b2b_st_we2", WE2, 0);

        // Reset in the middle of a load's REQ phase.
        $display("op=reset_mid_load addr=00000100");
        LSU_OP = 6'b001001; O = 32'h00000100; WA = 5'd4;
        step();
        LSU_OP = 6'b0;
        check("rmid_mreq_pre", MREQ, 1);
        #2 N_RST = 1'b0;
        #1;
        check("rmid_mreq", MREQ, 0);
        check("rmid_stall", STALL, 0);
        check("rmid_we2", WE2, 0);
        MACK = 1'b1; MRDATA = 32'h55AA55AA;
        step();
        #2 N_RST = 1'b1;
        MACK = 1'b0;
        step();
        check("rmid_after_we2", WE2, 0);
        check("rmid_after_stall", STALL, 0);
        step();
        check("rmid_after_we2b", WE2, 0);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 7);
            op = 6'($urandom);
            op[1:0] = (r < 3) ? 2'b01 : (r < 6) ? 2'b10 : (r == 6) ? 2'b11 : 2'b00;
            run_op(op, $urandom, $urandom, 5'($urandom), $urandom_range(1, TMO), $urandom);
        end

`ifdef LSU_TIMEOUT_EN
        $display("op=timeout_store addr=00000200");
        LSU_OP = 6'b001010; O = 32'h00000200; D = 32'h1;
        step();
        LSU_OP = 6'b0;
        cnt = 0;
        while (MREQ === 1'b1 && cnt < 20) begin
            cnt++;
            check("tmo_buserr_low", BUSERR, 0);
            step();
        end
        check("tmo_mreq_cycles", cnt, TMO);
        check("tmo_buserr", BUSERR, 1);
        check("tmo_stall", STALL, 0);
        check("tmo_we2", WE2, 0);
        step();
        check("tmo_buserr_clear", BUSERR, 0);
        check("tmo_we2b", WE2, 0);
        run_op(6'b001001, 32'h00000300, 32'h0, 5'd12, TMO, 32'h0BADF00D);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
